// File: rtl/lc3b_mem_pkg.sv
// Shared types and constants for the LC-3b memory-port initiator.
package lc3b_mem_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  localparam logic LANE_LO = 1'b0;
  localparam logic LANE_HI = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } mau_state_e;

  // Request attributes kept across the access for response formatting.
  typedef struct packed {
    logic write;
    logic byte_op;
    logic lane;
  } req_attr_t;

endpackage

// File: rtl/mem_lane_fmt.sv
// Byte-lane formatting: store replication/lane enables and load byte select + sign extension.
module mem_lane_fmt
  import lc3b_mem_pkg::*;
(
  input  logic        st_write,
  input  logic        st_byte,
  input  logic        st_lane,
  input  logic [15:0] st_data,
  output logic [15:0] st_out,
  output logic        we_lo,
  output logic        we_hi,
  input  logic        ld_byte,
  input  logic        ld_lane,
  input  logic [15:0] ld_raw,
  output logic [15:0] ld_out
);

  logic [7:0] ld_sel;

  always_comb begin
    st_out = st_byte ? {st_data[7:0], st_data[7:0]} : st_data;
    we_lo  = st_write & (~st_byte | (st_lane == LANE_LO));
    we_hi  = st_write & (~st_byte | (st_lane == LANE_HI));
    ld_sel = (ld_lane == LANE_HI) ? ld_raw[15:8] : ld_raw[7:0];
    ld_out = ld_byte ? {{8{ld_sel[7]}}, ld_sel} : ld_raw;
  end

endmodule

// File: rtl/mem_access_unit.sv
// Port-2 load/store initiator for the LC-3b block RAM; one request in flight, all outputs registered.
// Optional build macro MISALIGN_TRAP_EN: misaligned word accesses return respErr without touching memory.
module mem_access_unit
  import lc3b_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reqValid,
  output logic              reqReady,
  input  logic              reqWrite,
  input  logic              reqByte,
  input  logic [ADDR_W-1:0] reqAddr,
  input  logic [DATA_W-1:0] reqData,
  output logic              respValid,
  input  logic              respReady,
  output logic [DATA_W-1:0] respData,
  output logic              respErr,
  output logic              memEn,
  output logic [ADDR_W-1:0] memAddr,
  output logic              memWeLow,
  output logic              memWeHi,
  output logic [DATA_W-1:0] memDataOut,
  input  logic [DATA_W-1:0] memDataIn
);

  mau_state_e  state;
  req_attr_t   attr;
  logic [15:0] st_out, ld_out;
  logic        we_lo, we_hi;
  logic        misalign;

  // Store path formats the live request; load path formats the read data in CAPTURE.
  mem_lane_fmt u_fmt (
    .st_write (reqWrite),
    .st_byte  (reqByte),
    .st_lane  (reqAddr[0]),
    .st_data  (reqData),
    .st_out   (st_out),
    .we_lo    (we_lo),
    .we_hi    (we_hi),
    .ld_byte  (attr.byte_op),
    .ld_lane  (attr.lane),
    .ld_raw   (memDataIn),
    .ld_out   (ld_out)
  );

`ifdef MISALIGN_TRAP_EN
  assign misalign = ~reqByte & reqAddr[0];
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      attr       <= '0;
      reqReady   <= 1'b1;
      respValid  <= 1'b0;
      respData   <= '0;
      respErr    <= 1'b0;
      memEn      <= 1'b0;
      memAddr    <= '0;
      memWeLow   <= 1'b0;
      memWeHi    <= 1'b0;
      memDataOut <= '0;
    end else begin
      case (state)
        IDLE: if (reqValid && reqReady) begin
          attr     <= '{write: reqWrite, byte_op: reqByte, lane: reqAddr[0]};
          reqReady <= 1'b0;
          if (misalign) begin
            state     <= RESP;
            respValid <= 1'b1;
            respErr   <= 1'b1;
            respData  <= '0;
          end else begin
            state      <= ISSUE;
            memEn      <= 1'b1;
            memAddr    <= reqAddr;
            memWeLow   <= we_lo;
            memWeHi    <= we_hi;
            memDataOut <= reqWrite ? st_out : '0;
          end
        end
        ISSUE: begin
          // Memory samples en/we at the edge ending this cycle.
          state      <= CAPTURE;
          memEn      <= 1'b0;
          memWeLow   <= 1'b0;
          memWeHi    <= 1'b0;
          memAddr    <= '0;
          memDataOut <= '0;
        end
        CAPTURE: begin
          state     <= RESP;
          respValid <= 1'b1;
          respData  <= attr.write ? '0 : ld_out;
        end
        RESP: if (respReady) begin
          state     <= IDLE;
          respValid <= 1'b0;
          respErr   <= 1'b0;
          respData  <= '0;
          reqReady  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a block-RAM model and a byte-level reference memory.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        reqValid = 1'b0, reqWrite = 1'b0, reqByte = 1'b0;
  logic [15:0] reqAddr = '0, reqData = '0;
  logic        reqReady, respValid, respErr;
  logic        respReady = 1'b1;
  logic [15:0] respData;
  logic        memEn, memWeLow, memWeHi;
  logic [15:0] memAddr, memDataOut;
  logic [15:0] memDataIn;

  int n_tests = 0;
  int n_fail  = 0;

  mem_access_unit dut (
    .clk(clk), .rst_n(rst_n),
    .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite), .reqByte(reqByte),
    .reqAddr(reqAddr), .reqData(reqData),
    .respValid(respValid), .respReady(respReady), .respData(respData), .respErr(respErr),
    .memEn(memEn), .memAddr(memAddr), .memWeLow(memWeLow), .memWeHi(memWeHi),
    .memDataOut(memDataOut), .memDataIn(memDataIn)
  );

  always #5 clk = ~clk;

  // Block RAM model: synchronous read-first, byte write enables, word-addressed.
  bit [15:0] ram [0:32767];
  always @(posedge clk) begin
    if (memEn) begin
      memDataIn <= ram[memAddr[15:1]];
      if (memWeLow) ram[memAddr[15:1]][7:0]  <= memDataOut[7:0];
      if (memWeHi)  ram[memAddr[15:1]][15:8] <= memDataOut[15:8];
    end
  end

  // Reference: flat byte-addressed memory, little-endian words.
  bit [7:0] refm [0:65535];

  function automatic logic is_trap(input logic w, input logic b, input logic [15:0] a);
`ifdef MISALIGN_TRAP_EN
    return !b && a[0];
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [15:0] ref_load(input logic b, input logic [15:0] a);
    logic [7:0] v;
    if (b) begin
      v = refm[a];
      return {{8{v[7]}}, v};
    end
    return {refm[a | 16'h0001], refm[a & 16'hFFFE]};
  endfunction

  task automatic ref_store(input logic b, input logic [15:0] a, input logic [15:0] d);
    if (b) refm[a] = d[7:0];
    else begin
      refm[a & 16'hFFFE] = d[7:0];
      refm[a | 16'h0001] = d[15:8];
    end
  endtask

  // Per-transaction observations
  int          lat, en_cnt;
  logic        w_lo, w_hi, bad_we, rdy_hi, r_err;
  logic [15:0] m_addr, m_dout, r_data;
  time         t_acc;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic send_req(input logic w, input logic b, input logic [15:0] a, input logic [15:0] d);
    int k = 0;
    while (!reqReady && k < 20) begin tick(); k++; end
    if (!reqReady) begin
      n_tests++; n_fail++;
      $display("FAIL req_accept_timeout: reqReady=%b required 1", reqReady);
    end
    reqValid = 1'b1; reqWrite = w; reqByte = b; reqAddr = a; reqData = d;
    tick();
    t_acc = $time;
    reqValid = 1'b0;
  endtask

  task automatic wait_resp;
    lat = 1; en_cnt = 0; bad_we = 0; rdy_hi = 0;
    w_lo = 0; w_hi = 0; m_addr = '0; m_dout = '0;
    while (!respValid && lat < 20) begin
      if (memEn) begin
        en_cnt++; w_lo = memWeLow; w_hi = memWeHi; m_addr = memAddr; m_dout = memDataOut;
      end
      if ((memWeLow || memWeHi) && !memEn) bad_we = 1;
      if (reqReady) rdy_hi = 1;
      tick(); lat++;
    end
    if (!respValid) lat = -1;
    if (reqReady) rdy_hi = 1;
    r_data = respData; r_err = respErr;
  endtask

  task automatic txn(input logic w, input logic b, input logic [15:0] a, input logic [15:0] d);
    send_req(w, b, a, d);
    wait_resp();
    tick();
    if (w && !is_trap(w, b, a)) ref_store(b, a, d);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick(); tick();
    n_tests++;
    if (reqReady !== 1'b1) begin n_fail++; $display("FAIL reset_reqReady: got %b need 1", reqReady); end
    n_tests++;
    if ({respValid, respErr, respData} !== 18'h0) begin
      n_fail++; $display("FAIL reset_resp: got v=%b e=%b d=%h need zeros", respValid, respErr, respData);
    end
    n_tests++;
    if ({memEn, memWeLow, memWeHi, memAddr, memDataOut} !== 35'h0) begin
      n_fail++;
      $display("FAIL reset_mem: got en=%b wl=%b wh=%b a=%h d=%h need zeros", memEn, memWeLow, memWeHi, memAddr, memDataOut);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_word;
    txn(1'b1, 1'b0, 16'h1000, 16'hBEEF);
    n_tests++;
    if ({en_cnt == 1, w_lo, w_hi, m_addr, m_dout} !== {3'b111, 16'h1000, 16'hBEEF}) begin
      n_fail++;
      $display("FAIL stw_issue: got en_cnt=%0d wl=%b wh=%b a=%h d=%h need 1 1 1 1000 beef", en_cnt, w_lo, w_hi, m_addr, m_dout);
    end
    n_tests++;
    if (lat !== 3 || r_data !== 16'h0) begin
      n_fail++; $display("FAIL stw_resp: got lat=%0d d=%h need lat=3 d=0000", lat, r_data);
    end
    txn(1'b0, 1'b0, 16'h1000, 16'h0);
    n_tests++;
    if (r_data !== 16'hBEEF || w_lo || w_hi || lat !== 3) begin
      n_fail++; $display("FAIL ldw_1000: got d=%h wl=%b wh=%b lat=%0d need beef 0 0 3", r_data, w_lo, w_hi, lat);
    end
  endtask

  task automatic test_byte;
    txn(1'b1, 1'b1, 16'h1001, 16'h0080);
    n_tests++;
    if ({w_lo, w_hi, m_dout} !== {2'b01, 16'h8080}) begin
      n_fail++; $display("FAIL stb_lanes: got wl=%b wh=%b d=%h need 0 1 8080", w_lo, w_hi, m_dout);
    end
    txn(1'b0, 1'b1, 16'h1001, 16'h0);
    n_tests++;
    if (r_data !== 16'hFF80) begin n_fail++; $display("FAIL ldb_1001: got %h need ff80", r_data); end
    txn(1'b0, 1'b1, 16'h1000, 16'h0);
    n_tests++;
    if (r_data !== 16'hFFEF) begin n_fail++; $display("FAIL ldb_1000: got %h need ffef", r_data); end
    txn(1'b0, 1'b0, 16'h1000, 16'h0);
    n_tests++;
    if (r_data !== 16'h80EF) begin n_fail++; $display("FAIL ldw_merged: got %h need 80ef", r_data); end
  endtask

  task automatic test_backpressure;
    logic ok = 1'b1;
    respReady = 1'b0;
    send_req(1'b0, 1'b0, 16'h1000, 16'h0);
    wait_resp();
    for (int i = 0; i < 5; i++) begin
      tick();
      if (!respValid || respData !== 16'h80EF || reqReady || memEn) ok = 1'b0;
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL backpressure_hold: got v=%b d=%h rdy=%b en=%b need 1 80ef 0 0", respValid, respData, reqReady, memEn);
    end
    respReady = 1'b1;
    tick();
    n_tests++;
    if (respValid !== 1'b0 || reqReady !== 1'b1) begin
      n_fail++; $display("FAIL backpressure_release: got v=%b rdy=%b need 0 1", respValid, reqReady);
    end
  endtask

  task automatic test_reset_mid;
    logic seen = 1'b0;
    send_req(1'b0, 1'b0, 16'h1000, 16'h0);
    tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (respValid || !reqReady) seen = 1'b1;
      tick();
    end
    n_tests++;
    if (seen) begin n_fail++; $display("FAIL reset_capture: response or busy seen after reset, need idle"); end
    send_req(1'b1, 1'b0, 16'h2000, 16'h1234);
    n_tests++;
    if (memEn !== 1'b1) begin n_fail++; $display("FAIL reset_issue_en: got memEn=%b need 1", memEn); end
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    ref_store(1'b0, 16'h2000, 16'h1234);
    n_tests++;
    if (reqReady !== 1'b1 || memEn !== 1'b0 || respValid !== 1'b0) begin
      n_fail++; $display("FAIL reset_issue_idle: got rdy=%b en=%b v=%b need 1 0 0", reqReady, memEn, respValid);
    end
    txn(1'b0, 1'b0, 16'h2000, 16'h0);
    n_tests++;
    if (r_data !== 16'h1234) begin n_fail++; $display("FAIL reset_issue_write: got %h need 1234", r_data); end
  endtask

  task automatic test_misalign;
    txn(1'b0, 1'b0, 16'h1001, 16'h0);
    n_tests++;
`ifdef MISALIGN_TRAP_EN
    if (lat !== 1 || r_err !== 1'b1 || en_cnt !== 0 || r_data !== 16'h0) begin
      n_fail++; $display("FAIL misalign_trap: got lat=%0d err=%b en=%0d d=%h need 1 1 0 0000", lat, r_err, en_cnt, r_data);
    end
`else
    if (lat !== 3 || r_err !== 1'b0 || r_data !== 16'h80EF) begin
      n_fail++; $display("FAIL misalign_word: got lat=%0d err=%b d=%h need 3 0 80ef", lat, r_err, r_data);
    end
`endif
    n_tests++;
    if (respErr !== 1'b0) begin n_fail++; $display("FAIL misalign_err_clear: got %b need 0", respErr); end
  endtask

  task automatic test_back_to_back;
    time t0;
    txn(1'b1, 1'b0, 16'hFFFE, 16'hA55A);
    t0 = t_acc;
    send_req(1'b0, 1'b1, 16'hFFFF, 16'h0);
    wait_resp();
    tick();
    n_tests++;
    if ((t_acc - t0) !== 40 || rdy_hi) begin
      n_fail++; $display("FAIL back_to_back: got gap=%0t rdy_busy=%b need 40 0", t_acc - t0, rdy_hi);
    end
    n_tests++;
    if (r_data !== 16'hFFA5) begin n_fail++; $display("FAIL addr_wrap_ldb: got %h need ffa5", r_data); end
  endtask

  task automatic test_random;
    logic w, b, trap;
    logic [15:0] a, d, exp_d, exp_o;
    for (int i = 0; i < 300; i++) begin
      w = 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
      a = (($urandom_range(0, 1) != 0) ? 16'hFFE0 : 16'h3000) | 16'($urandom_range(0, 31));
      d = 16'($urandom);
      trap = is_trap(w, b, a);
      exp_d = (w || trap) ? 16'h0 : ref_load(b, a);
      exp_o = b ? {d[7:0], d[7:0]} : d;
      respReady = ($urandom_range(0, 3) != 0);
      send_req(w, b, a, d);
      wait_resp();
      if (!respReady) begin
        repeat ($urandom_range(1, 3)) tick();
        respReady = 1'b1;
      end
      tick();
      if (w && !trap) ref_store(b, a, d);
      n_tests++;
      if (trap) begin
        if (lat !== 1 || r_err !== 1'b1 || en_cnt !== 0 || r_data !== 16'h0) begin
          n_fail++; $display("FAIL rnd_trap[%0d]: a=%h got lat=%0d err=%b en=%0d d=%h", i, a, lat, r_err, en_cnt, r_data);
        end
      end else if (lat !== 3 || r_err !== 1'b0 || r_data !== exp_d || en_cnt !== 1 || bad_we || rdy_hi) begin
        n_fail++;
        $display("FAIL rnd_resp[%0d]: w=%b b=%b a=%h got lat=%0d err=%b d=%h en=%0d badwe=%b rdy=%b need d=%h",
                 i, w, b, a, lat, r_err, r_data, en_cnt, bad_we, rdy_hi, exp_d);
      end
      if (!trap) begin
        n_tests++;
        if (m_addr !== a || w_lo !== (w && (!b || !a[0])) || w_hi !== (w && (!b || a[0])) ||
            (w && m_dout !== exp_o)) begin
          n_fail++;
          $display("FAIL rnd_issue[%0d]: w=%b b=%b got a=%h wl=%b wh=%b d=%h need a=%h d=%h",
                   i, w, b, m_addr, w_lo, w_hi, m_dout, a, exp_o);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_backpressure();
    test_reset_mid();
    test_misalign();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
